// File: rtl/digit_scheduler_if.sv
// Handshake and data bundle between the display scan/stopwatch logic and the
// digit scheduler. The master drives pulses, clears and lookup requests; the
// slave (the scheduler) returns the glyph-memory address pair and the digits.
interface digit_scheduler_if;
    logic        enable_ds;
    logic        clr_ds;
    logic [1:0]  stm_p_ds;
    logic        req_ds;
    logic [2:0]  pos_ds;
    logic        ack_out;
    logic [2:0]  mem_position_out;
    logic [3:0]  mem_id_out;
    logic [15:0] digits_out;
    logic        ovf_out;

    modport master (
        output enable_ds,
        output clr_ds,
        output stm_p_ds,
        output req_ds,
        output pos_ds,
        input  ack_out,
        input  mem_position_out,
        input  mem_id_out,
        input  digits_out,
        input  ovf_out
    );

    modport slave (
        input  enable_ds,
        input  clr_ds,
        input  stm_p_ds,
        input  req_ds,
        input  pos_ds,
        output ack_out,
        output mem_position_out,
        output mem_id_out,
        output digits_out,
        output ovf_out
    );
endinterface

// File: rtl/digit_scheduler.sv
// Scoreboard stopwatch controller. Keeps four BCD digits (MM:SS), advances
// them from stopwatch pulse codes and answers display-scan digit lookups.
// A single FSM owns the digit registers; count updates win over lookups, and
// one pulse can be parked while the FSM is busy.
module digit_scheduler #(
    parameter logic [3:0] SEC_U_MAX = 4'd9,
    parameter logic [3:0] SEC_T_MAX = 4'd5,
    parameter logic [3:0] MIN_U_MAX = 4'd9,
    parameter logic [3:0] MIN_T_MAX = 4'd9
) (
    input logic             clk_ds,
    input logic             rst_ds,
    digit_scheduler_if.slave ds
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UPD  = 2'd1,
        ST_LOAD = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [2:0] NULL_POS = 3'b111;
    localparam logic [3:0] NULL_ID  = 4'b1010;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] digits_r;
    logic [15:0] digits_s;
    logic        pend_valid_r;
    logic        pend_valid_s;
    logic [1:0]  pend_code_r;
    logic [1:0]  pend_code_s;
    logic [1:0]  upd_code_r;
    logic [1:0]  upd_code_s;
    logic        clr_pend_r;
    logic        clr_pend_s;
    logic        ack_r;
    logic        ack_s;
    logic [2:0]  mem_pos_r;
    logic [2:0]  mem_pos_s;
    logic [3:0]  mem_id_r;
    logic [3:0]  mem_id_s;
    logic        ovf_r;
    logic        ovf_s;
    logic        pulse_s;

    // One digit step: compare against the wrap value before adding so an
    // out-of-range value can never be produced.
    function automatic logic [3:0] step_digit(input logic [3:0] d,
                                              input logic [3:0] max_v,
                                              input logic       inc);
        logic [3:0] r;
        if (!inc) begin
            r = d;
        end else if (d == max_v) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    // Apply one pulse code to the packed digits with the full carry chain.
    // Tens-of-minutes wraps to zero without carrying anywhere.
    function automatic logic [15:0] advance_digits(input logic [15:0] d,
                                                   input logic [1:0]  code);
        logic inc0;
        logic inc1;
        logic inc2;
        logic inc3;
        inc0 = (code == 2'b01);
        inc1 = (code == 2'b10) || (inc0 && (d[3:0]   == SEC_U_MAX));
        inc2 = (code == 2'b11) || (inc1 && (d[7:4]   == SEC_T_MAX));
        inc3 = inc2 && (d[11:8] == MIN_U_MAX);
        return {step_digit(d[15:12], MIN_T_MAX, inc3),
                step_digit(d[11:8],  MIN_U_MAX, inc2),
                step_digit(d[7:4],   SEC_T_MAX, inc1),
                step_digit(d[3:0],   SEC_U_MAX, inc0)};
    endfunction

    // Digit selected by a display position; positions 4..7 map to the null glyph.
    function automatic logic [3:0] pick_digit(input logic [15:0] d,
                                              input logic [2:0]  pos);
        logic [3:0] r;
        case (pos)
            3'd0:    r = d[3:0];
            3'd1:    r = d[7:4];
            3'd2:    r = d[11:8];
            3'd3:    r = d[15:12];
            default: r = NULL_ID;
        endcase
        return r;
    endfunction

    // Glyph-memory position for a display position; out-of-range gives null.
    function automatic logic [2:0] pick_position(input logic [2:0] pos);
        logic [2:0] r;
        if (pos[2]) begin
            r = NULL_POS;
        end else begin
            r = pos;
        end
        return r;
    endfunction

    assign pulse_s = (ds.stm_p_ds != 2'b00);

    // Next-state and next-register logic: enable gating, arbitration, pulse parking.
    always_comb begin
        state_s      = state_r;
        digits_s     = digits_r;
        pend_valid_s = pend_valid_r;
        pend_code_s  = pend_code_r;
        upd_code_s   = upd_code_r;
        clr_pend_s   = clr_pend_r;
        ack_s        = 1'b0;
        mem_pos_s    = mem_pos_r;
        mem_id_s     = mem_id_r;
        ovf_s        = ovf_r;

        if (!ds.enable_ds) begin
            // Disabled: abandon any transaction, drop the parked pulse, show null.
            state_s      = ST_IDLE;
            pend_valid_s = 1'b0;
            pend_code_s  = 2'b00;
            clr_pend_s   = 1'b0;
            mem_pos_s    = NULL_POS;
            mem_id_s     = NULL_ID;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ds.clr_ds || clr_pend_r) begin
                        digits_s     = 16'h0000;
                        pend_valid_s = 1'b0;
                        pend_code_s  = 2'b00;
                        clr_pend_s   = 1'b0;
                    end else if (pend_valid_r) begin
                        // Older parked pulse goes first; a fresh one takes its slot.
                        state_s      = ST_UPD;
                        upd_code_s   = pend_code_r;
                        pend_valid_s = pulse_s;
                        pend_code_s  = ds.stm_p_ds;
                    end else if (pulse_s) begin
                        state_s    = ST_UPD;
                        upd_code_s = ds.stm_p_ds;
                    end else if (ds.req_ds) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_UPD: begin
                    digits_s = advance_digits(digits_r, upd_code_r);
                    state_s  = ST_IDLE;
                end
                ST_LOAD: begin
                    mem_pos_s = pick_position(ds.pos_ds);
                    mem_id_s  = pick_digit(digits_r, ds.pos_ds);
                    ack_s     = 1'b1;
                    state_s   = ST_RESP;
                end
                ST_RESP: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase

            if (state_r != ST_IDLE) begin
                // Busy: park one pulse, flag any pulse beyond that as lost.
                if (pulse_s && pend_valid_r) begin
                    ovf_s = 1'b1;
                end else if (pulse_s) begin
                    pend_valid_s = 1'b1;
                    pend_code_s  = ds.stm_p_ds;
                end else begin
                    ovf_s = ovf_r;
                end
                // A clear seen while busy is remembered for the next idle cycle.
                if (ds.clr_ds) begin
                    clr_pend_s = 1'b1;
                end else begin
                    clr_pend_s = clr_pend_r;
                end
            end else begin
                ovf_s = ovf_r;
            end
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk_ds) begin
        if (rst_ds) begin
            state_r      <= ST_IDLE;
            digits_r     <= 16'h0000;
            pend_valid_r <= 1'b0;
            pend_code_r  <= 2'b00;
            upd_code_r   <= 2'b00;
            clr_pend_r   <= 1'b0;
            ack_r        <= 1'b0;
            mem_pos_r    <= 3'b000;
            mem_id_r     <= 4'b0000;
            ovf_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            digits_r     <= digits_s;
            pend_valid_r <= pend_valid_s;
            pend_code_r  <= pend_code_s;
            upd_code_r   <= upd_code_s;
            clr_pend_r   <= clr_pend_s;
            ack_r        <= ack_s;
            mem_pos_r    <= mem_pos_s;
            mem_id_r     <= mem_id_s;
            ovf_r        <= ovf_s;
        end
    end

    assign ds.ack_out          = ack_r;
    assign ds.mem_position_out = mem_pos_r;
    assign ds.mem_id_out       = mem_id_r;
    assign ds.digits_out       = digits_r;
    assign ds.ovf_out          = ovf_r;

endmodule
